// File: rtl/mem_access_unit.sv
// Sequential memory stage: runs loads/stores as multi-beat req/ack transactions
// over a narrow memctl bus, extends load data and retires results to WB.
module mem_access_unit #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int BUS_BYTES = 1
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   in_valid,
  input  logic                   in_is_load,
  input  logic                   in_is_store,
  input  logic [2:0]             in_funct3,
  input  logic [REG_AW-1:0]      in_rd_addr,
  input  logic [XLEN-1:0]        in_rd_val,
  input  logic                   in_forward,
  input  logic [XLEN-1:0]        in_mem_addr,
  input  logic [XLEN-1:0]        in_mem_val,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [1:0]             mem_len,
  output logic [XLEN-1:0]        mem_addr,
  output logic [8*BUS_BYTES-1:0] mem_wdata,
  input  logic                   mem_ack,
  input  logic [8*BUS_BYTES-1:0] mem_rdata,
  output logic                   stall,
  output logic                   wb_valid,
  output logic [REG_AW-1:0]      wb_rd_addr,
  output logic [XLEN-1:0]        wb_rd_val,
  output logic                   fwd_valid,
  output logic [REG_AW-1:0]      fwd_rd_addr,
  output logic [XLEN-1:0]        fwd_rd_val,
  output logic                   err
);

  localparam int LGB    = (BUS_BYTES == 4) ? 2 : (BUS_BYTES == 2) ? 1 : 0;
  localparam int LANE_W = 8 * BUS_BYTES;
  localparam int MAXB   = 4 / BUS_BYTES;

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;
  state_t state, state_nxt;

  logic [1:0]        beat_cnt;
  logic [XLEN-1:0]   base_q;
  logic [31:0]       data_q;
  logic [31:0]       buf_q;
  logic [2:0]        f3_q;
  logic [REG_AW-1:0] rd_q;
  logic              store_q;

  logic       mem_op, is_st, legal, aligned, start;
  logic [1:0] last_k, beat_len, lg_diff;

  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [31:0] b);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] sw;
    sb = b[7:0];
    sh = b[15:0];
    sw = b;
    case (f3)
      3'b000:  load_extend = XLEN'(sb);
      3'b001:  load_extend = XLEN'(sh);
      3'b100:  load_extend = XLEN'(b[7:0]);
      3'b101:  load_extend = XLEN'(b[15:0]);
      default: load_extend = XLEN'(sw);
    endcase
  endfunction

  always_comb begin
    mem_op = in_is_load | in_is_store;
    is_st  = in_is_store & ~in_is_load;
    if (is_st) legal = (in_funct3 == 3'b000) | (in_funct3 == 3'b001) | (in_funct3 == 3'b010);
    else       legal = (in_funct3 == 3'b000) | (in_funct3 == 3'b001) | (in_funct3 == 3'b010) |
                       (in_funct3 == 3'b100) | (in_funct3 == 3'b101);
    case (in_funct3[1:0])
      2'b01:   aligned = ~in_mem_addr[0];
      2'b10:   aligned = (in_mem_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    start = in_valid & mem_op & legal & aligned;
  end

  // Beat geometry from the latched access size versus the bus width.
  always_comb begin
    lg_diff  = 2'b00;
    beat_len = f3_q[1:0];
    if (f3_q[1:0] > 2'(LGB)) begin
      lg_diff  = f3_q[1:0] - 2'(LGB);
      beat_len = 2'(LGB);
    end
    last_k = (lg_diff == 2'd2) ? 2'd3 : (lg_diff == 2'd1) ? 2'd1 : 2'd0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      state <= IDLE;
    else if (rdy_in) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_len   = 2'b00;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        stall = start;
        if (start) state_nxt = BEAT;
      end
      BEAT: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_we   = store_q;
        mem_len  = beat_len;
        mem_addr = base_q + (XLEN'(beat_cnt) << LGB);
        for (int b = 0; b < MAXB; b++)
          if (beat_cnt == 2'(b)) mem_wdata = data_q[b*LANE_W +: LANE_W];
        if (mem_ack && beat_cnt == last_k) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      beat_cnt    <= '0;
      base_q      <= '0;
      data_q      <= '0;
      buf_q       <= '0;
      f3_q        <= '0;
      rd_q        <= '0;
      store_q     <= 1'b0;
      wb_valid    <= 1'b0;
      wb_rd_addr  <= '0;
      wb_rd_val   <= '0;
      fwd_valid   <= 1'b0;
      fwd_rd_addr <= '0;
      fwd_rd_val  <= '0;
      err         <= 1'b0;
    end else if (rdy_in) begin
      wb_valid  <= 1'b0;
      fwd_valid <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && !mem_op) begin
            wb_valid    <= 1'b1;
            wb_rd_addr  <= in_rd_addr;
            wb_rd_val   <= in_rd_val;
            fwd_valid   <= in_forward;
            fwd_rd_addr <= in_rd_addr;
            fwd_rd_val  <= in_rd_val;
          end else if (start) begin
            base_q   <= in_mem_addr;
            data_q   <= in_mem_val[31:0];
            f3_q     <= in_funct3;
            rd_q     <= in_rd_addr;
            store_q  <= is_st;
            beat_cnt <= '0;
            buf_q    <= '0;
          end else if (in_valid) begin
            err        <= 1'b1;
            wb_valid   <= 1'b1;
            wb_rd_addr <= '0;
            wb_rd_val  <= '0;
          end
        end
        BEAT: begin
          if (mem_ack) begin
            if (!store_q)
              for (int j = 0; j < 4; j++)
                if (2'(j / BUS_BYTES) == beat_cnt) buf_q[j*8 +: 8] <= mem_rdata[(j % BUS_BYTES)*8 +: 8];
            if (beat_cnt != last_k) beat_cnt <= beat_cnt + 2'd1;
          end
        end
        DONE: begin
          wb_valid <= 1'b1;
          if (store_q) begin
            wb_rd_addr <= '0;
            wb_rd_val  <= '0;
          end else begin
            wb_rd_addr  <= rd_q;
            wb_rd_val   <= load_extend(f3_q, buf_q);
            fwd_valid   <= 1'b1;
            fwd_rd_addr <= rd_q;
            fwd_rd_val  <= load_extend(f3_q, buf_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: three instances at bus widths 1, 2 and 4 bytes.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy;
  logic        in_is_load, in_is_store, in_forward;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd_addr;
  logic [31:0] in_rd_val, in_mem_addr, in_mem_val;

  logic v1, ack1, req1, we1, stall1, wbv1, fv1, err1;
  logic [1:0] len1;
  logic [7:0] rdata1, wdata1;
  logic [4:0] wba1, fa1;
  logic [31:0] addr1, wbd1, fd1;

  logic v2, ack2, req2, we2, stall2, wbv2, fv2, err2;
  logic [1:0] len2;
  logic [15:0] rdata2, wdata2;
  logic [4:0] wba2, fa2;
  logic [31:0] addr2, wbd2, fd2;

  logic v4, ack4, req4, we4, stall4, wbv4, fv4, err4;
  logic [1:0] len4;
  logic [31:0] rdata4, wdata4;
  logic [4:0] wba4, fa4;
  logic [31:0] addr4, wbd4, fd4;

  mem_access_unit #(.XLEN(32), .REG_AW(5), .BUS_BYTES(1)) dut_b1 (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .in_valid(v1), .in_is_load(in_is_load),
    .in_is_store(in_is_store), .in_funct3(in_funct3), .in_rd_addr(in_rd_addr), .in_rd_val(in_rd_val),
    .in_forward(in_forward), .in_mem_addr(in_mem_addr), .in_mem_val(in_mem_val),
    .mem_req(req1), .mem_we(we1), .mem_len(len1), .mem_addr(addr1), .mem_wdata(wdata1),
    .mem_ack(ack1), .mem_rdata(rdata1), .stall(stall1), .wb_valid(wbv1), .wb_rd_addr(wba1),
    .wb_rd_val(wbd1), .fwd_valid(fv1), .fwd_rd_addr(fa1), .fwd_rd_val(fd1), .err(err1));

  mem_access_unit #(.XLEN(32), .REG_AW(5), .BUS_BYTES(2)) dut_b2 (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .in_valid(v2), .in_is_load(in_is_load),
    .in_is_store(in_is_store), .in_funct3(in_funct3), .in_rd_addr(in_rd_addr), .in_rd_val(in_rd_val),
    .in_forward(in_forward), .in_mem_addr(in_mem_addr), .in_mem_val(in_mem_val),
    .mem_req(req2), .mem_we(we2), .mem_len(len2), .mem_addr(addr2), .mem_wdata(wdata2),
    .mem_ack(ack2), .mem_rdata(rdata2), .stall(stall2), .wb_valid(wbv2), .wb_rd_addr(wba2),
    .wb_rd_val(wbd2), .fwd_valid(fv2), .fwd_rd_addr(fa2), .fwd_rd_val(fd2), .err(err2));

  mem_access_unit #(.XLEN(32), .REG_AW(5), .BUS_BYTES(4)) dut_b4 (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .in_valid(v4), .in_is_load(in_is_load),
    .in_is_store(in_is_store), .in_funct3(in_funct3), .in_rd_addr(in_rd_addr), .in_rd_val(in_rd_val),
    .in_forward(in_forward), .in_mem_addr(in_mem_addr), .in_mem_val(in_mem_val),
    .mem_req(req4), .mem_we(we4), .mem_len(len4), .mem_addr(addr4), .mem_wdata(wdata4),
    .mem_ack(ack4), .mem_rdata(rdata4), .stall(stall4), .wb_valid(wbv4), .wb_rd_addr(wba4),
    .wb_rd_val(wbd4), .fwd_valid(fv4), .fwd_rd_addr(fa4), .fwd_rd_val(fd4), .err(err4));

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic ld, input logic st, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] addr, input logic [31:0] val);
    in_is_load  = ld;
    in_is_store = st;
    in_funct3   = f3;
    in_rd_addr  = rd;
    in_mem_addr = addr;
    in_mem_val  = val;
  endtask

  task automatic run_b4(input string tag, input logic [2:0] f3, input logic [31:0] rd_data,
                        input logic [1:0] exp_len, input logic [31:0] exp_val);
    set_op(1'b1, 1'b0, f3, 5'd1, 32'h40, 32'h0);
    v4 = 1'b1;
    tick;
    v4 = 1'b0;
    check({tag, "_req"}, {31'b0, req4}, 32'd1);
    check({tag, "_len"}, {30'b0, len4}, {30'b0, exp_len});
    ack4   = 1'b1;
    rdata4 = rd_data;
    tick;
    ack4 = 1'b0;
    check({tag, "_done_req"}, {31'b0, req4}, 32'd0);
    tick;
    check({tag, "_wbv"}, {31'b0, wbv4}, 32'd1);
    check({tag, "_val"}, wbd4, exp_val);
    tick;
  endtask

  task automatic err_case(input string tag, input logic [2:0] f3, input logic [31:0] addr);
    set_op(1'b1, 1'b0, f3, 5'd7, addr, 32'h0);
    v1 = 1'b1;
    #1;
    check({tag, "_stall"}, {31'b0, stall1}, 32'd0);
    check({tag, "_req"}, {31'b0, req1}, 32'd0);
    tick;
    v1 = 1'b0;
    check({tag, "_err"}, {31'b0, err1}, 32'd1);
    check({tag, "_wbv"}, {31'b0, wbv1}, 32'd1);
    check({tag, "_wba"}, {27'b0, wba1}, 32'd0);
    check({tag, "_wbd"}, wbd1, 32'd0);
    check({tag, "_fv"}, {31'b0, fv1}, 32'd0);
    check({tag, "_req2"}, {31'b0, req1}, 32'd0);
    tick;
    check({tag, "_err_clr"}, {31'b0, err1}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] lw_b[4];
    logic [7:0] lw_c[4];
    lw_b = '{8'h78, 8'h56, 8'h34, 8'h12};
    lw_c = '{8'h44, 8'h33, 8'h22, 8'h11};
    rst = 1'b1; rdy = 1'b1;
    v1 = 0; v2 = 0; v4 = 0; ack1 = 0; ack2 = 0; ack4 = 0;
    rdata1 = '0; rdata2 = '0; rdata4 = '0;
    in_rd_val = '0; in_forward = 1'b0;
    set_op(1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'b0, req1}, 32'd0);
    check("rst_wbv", {31'b0, wbv1}, 32'd0);
    check("rst_stall", {31'b0, stall1}, 32'd0);
    check("rst_addr", addr1, 32'd0);
    check("rst_wbd", wbd4, 32'd0);
    rst = 1'b0;
    tick;

    // LW over a byte-wide bus, each ack one cycle late
    set_op(1'b1, 1'b0, 3'b010, 5'd3, 32'h100, 32'h0);
    v1 = 1'b1;
    #1;
    check("lw_stall_start", {31'b0, stall1}, 32'd1);
    check("lw_req_idle", {31'b0, req1}, 32'd0);
    tick;
    v1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("lw_addr", addr1, 32'h100 + k);
      check("lw_req", {31'b0, req1}, 32'd1);
      check("lw_len", {30'b0, len1}, 32'd0);
      check("lw_stall", {31'b0, stall1}, 32'd1);
      tick;
      check("lw_addr_hold", addr1, 32'h100 + k);
      ack1   = 1'b1;
      rdata1 = lw_b[k];
      tick;
      ack1 = 1'b0;
    end
    check("lw_done_stall", {31'b0, stall1}, 32'd0);
    check("lw_done_req", {31'b0, req1}, 32'd0);
    check("lw_done_wbv", {31'b0, wbv1}, 32'd0);
    tick;
    check("lw_wbv", {31'b0, wbv1}, 32'd1);
    check("lw_wbd", wbd1, 32'h12345678);
    check("lw_wba", {27'b0, wba1}, 32'd3);
    check("lw_fv", {31'b0, fv1}, 32'd1);
    tick;
    check("lw_wbv_pulse", {31'b0, wbv1}, 32'd0);

    // Sign/zero extension on a word-wide bus
    run_b4("lb", 3'b000, 32'h00000080, 2'd0, 32'hFFFFFF80);
    run_b4("lhu", 3'b101, 32'h00008001, 2'd1, 32'h00008001);
    run_b4("lh", 3'b001, 32'h00008001, 2'd1, 32'hFFFF8001);

    // SW over a halfword bus
    set_op(1'b0, 1'b1, 3'b010, 5'd9, 32'h200, 32'hDEADBEEF);
    v2 = 1'b1;
    tick;
    v2 = 1'b0;
    check("sw_addr0", addr2, 32'h200);
    check("sw_wdata0", {16'b0, wdata2}, 32'h0000BEEF);
    check("sw_we0", {31'b0, we2}, 32'd1);
    check("sw_len", {30'b0, len2}, 32'd1);
    ack2 = 1'b1;
    tick;
    ack2 = 1'b0;
    check("sw_addr1", addr2, 32'h202);
    check("sw_wdata1", {16'b0, wdata2}, 32'h0000DEAD);
    check("sw_we1", {31'b0, we2}, 32'd1);
    ack2 = 1'b1;
    tick;
    ack2 = 1'b0;
    check("sw_done_req", {31'b0, req2}, 32'd0);
    tick;
    check("sw_wbv", {31'b0, wbv2}, 32'd1);
    check("sw_wba", {27'b0, wba2}, 32'd0);
    check("sw_wbd", wbd2, 32'd0);
    check("sw_fv", {31'b0, fv2}, 32'd0);
    tick;

    err_case("misalign", 3'b010, 32'h102);
    err_case("illegal", 3'b011, 32'h100);

    // Reset during beat 2 of a 4-beat load
    set_op(1'b1, 1'b0, 3'b010, 5'd3, 32'h100, 32'h0);
    v1 = 1'b1;
    tick;
    v1 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ack1   = 1'b1;
      rdata1 = 8'hAA;
      tick;
      ack1 = 1'b0;
    end
    check("rstmid_addr", addr1, 32'h102);
    check("rstmid_req", {31'b0, req1}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid_req_drop", {31'b0, req1}, 32'd0);
    check("rstmid_stall", {31'b0, stall1}, 32'd0);
    tick;
    rst = 1'b0;
    tick;
    set_op(1'b0, 1'b0, 3'b000, 5'd5, 32'h0, 32'h0);
    in_rd_val  = 32'd7;
    in_forward = 1'b1;
    v1 = 1'b1;
    #1;
    check("alu_stall", {31'b0, stall1}, 32'd0);
    tick;
    v1 = 1'b0;
    check("alu_wbv", {31'b0, wbv1}, 32'd1);
    check("alu_wbd", wbd1, 32'd7);
    check("alu_wba", {27'b0, wba1}, 32'd5);
    check("alu_fv", {31'b0, fv1}, 32'd1);
    check("alu_fd", fd1, 32'd7);
    tick;

    // rdy_in low mid-transaction with a stray ack
    in_forward = 1'b0;
    set_op(1'b1, 1'b0, 3'b010, 5'd4, 32'h104, 32'h0);
    v1 = 1'b1;
    tick;
    v1 = 1'b0;
    ack1   = 1'b1;
    rdata1 = lw_c[0];
    tick;
    ack1 = 1'b0;
    check("rdy_addr_pre", addr1, 32'h105);
    rdy    = 1'b0;
    ack1   = 1'b1;
    rdata1 = 8'hEE;
    repeat (3) begin
      tick;
      check("rdy_addr_frozen", addr1, 32'h105);
      check("rdy_req_frozen", {31'b0, req1}, 32'd1);
      check("rdy_stall_frozen", {31'b0, stall1}, 32'd1);
    end
    rdy  = 1'b1;
    ack1 = 1'b0;
    #1;
    check("rdy_addr_post", addr1, 32'h105);
    for (int k = 1; k < 4; k++) begin
      ack1   = 1'b1;
      rdata1 = lw_c[k];
      tick;
      ack1 = 1'b0;
    end
    tick;
    check("rdy_wbv", {31'b0, wbv1}, 32'd1);
    check("rdy_wbd", wbd1, 32'h11223344);
    check("rdy_wba", {27'b0, wba1}, 32'd4);
    tick;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
